// File: rtl/keyboard_pkg.sv
// Shared definitions for the PS/2 keyboard source: scancode constants,
// receiver state encoding, decoder flag bundle and default frame timeout.
package keyboard_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 200000;
  localparam int unsigned BIT_CNT_W              = 3;

  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Scancode decoder modifier state
  typedef struct packed {
    logic shift;
    logic brk;
    logic ext;
  } kb_flags_t;

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational set-2 scancode to ASCII lookup.
// Ports:
//   code_i    - set-2 make code
//   shift_i   - shift held; selects upper-case letters
//   ascii_o_c - ASCII result, 0x00 for unmapped codes
module scancode_to_ascii (
  input  logic [7:0] code_i,
  input  logic       shift_i,
  output logic [7:0] ascii_o_c
);

  logic [7:0] lower_c;

  // Letter keys, lower-case form
  always_comb begin
    lower_c = 8'h00;
    case (code_i)
      8'h1C: lower_c = 8'h61; 8'h32: lower_c = 8'h62; 8'h21: lower_c = 8'h63;
      8'h23: lower_c = 8'h64; 8'h24: lower_c = 8'h65; 8'h2B: lower_c = 8'h66;
      8'h34: lower_c = 8'h67; 8'h33: lower_c = 8'h68; 8'h43: lower_c = 8'h69;
      8'h3B: lower_c = 8'h6A; 8'h42: lower_c = 8'h6B; 8'h4B: lower_c = 8'h6C;
      8'h3A: lower_c = 8'h6D; 8'h31: lower_c = 8'h6E; 8'h44: lower_c = 8'h6F;
      8'h4D: lower_c = 8'h70; 8'h15: lower_c = 8'h71; 8'h2D: lower_c = 8'h72;
      8'h1B: lower_c = 8'h73; 8'h2C: lower_c = 8'h74; 8'h3C: lower_c = 8'h75;
      8'h2A: lower_c = 8'h76; 8'h1D: lower_c = 8'h77; 8'h22: lower_c = 8'h78;
      8'h35: lower_c = 8'h79; 8'h1A: lower_c = 8'h7A;
      default: lower_c = 8'h00;
    endcase
  end

  // Letters take shift; digits and control keys do not
  always_comb begin
    ascii_o_c = 8'h00;
    if (lower_c != 8'h00) begin
      ascii_o_c = shift_i ? (lower_c - 8'h20) : lower_c;
    end else begin
      case (code_i)
        8'h16: ascii_o_c = 8'h31; 8'h1E: ascii_o_c = 8'h32; 8'h26: ascii_o_c = 8'h33;
        8'h25: ascii_o_c = 8'h34; 8'h2E: ascii_o_c = 8'h35; 8'h36: ascii_o_c = 8'h36;
        8'h3D: ascii_o_c = 8'h37; 8'h3E: ascii_o_c = 8'h38; 8'h46: ascii_o_c = 8'h39;
        8'h45: ascii_o_c = 8'h30;
        8'h29: ascii_o_c = 8'h20;
        8'h5A: ascii_o_c = 8'h0D;
        8'h66: ascii_o_c = 8'h08;
        default: ascii_o_c = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/keyboard_source.sv
// PS/2 keyboard receiver and set-2 decoder producing ASCII key presses.
// Ports:
//   clock, resetn  - system clock, async active-low reset
//   ps2_clk/data   - raw asynchronous PS/2 lines
//   key_reg        - ASCII of the most recent accepted key press
//   sample         - toggles once per new key_reg value (resets to 1)
//   frame_err      - one-cycle pulse when a frame is discarded
module keyboard_source
  import keyboard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_reg,
  output logic       sample,
  output logic       frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic                 clk_meta_q, clk_sync_q, clk_prev_q;
  logic                 dat_meta_q, dat_sync_q;
  ps2_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  kb_flags_t            flags_q, flags_d;
  logic [7:0]           key_reg_q, key_reg_d;
  logic                 sample_q, sample_d;
  logic                 frame_err_q, frame_err_d;

  logic                 fall_c;
  logic                 timeout_c;
  logic                 frame_ok_c;
  logic [7:0]           ascii_c;

  scancode_to_ascii u_lut (
    .code_i    (shreg_q),
    .shift_i   (flags_q.shift),
    .ascii_o_c (ascii_c)
  );

  assign fall_c     = clk_prev_q & ~clk_sync_q;
  assign timeout_c  = (state_q != ST_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  // Odd parity across data+parity, stop bit high
  assign frame_ok_c = (^{shreg_q, parity_q}) & dat_sync_q;

  // State register, including line synchronizers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_meta_q  <= 1'b1;
      dat_sync_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      flags_q     <= '0;
      key_reg_q   <= 8'h00;
      sample_q    <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      dat_meta_q  <= ps2_data;
      dat_sync_q  <= dat_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      flags_q     <= flags_d;
      key_reg_q   <= key_reg_d;
      sample_q    <= sample_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame receiver and scancode decoder next-state
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    to_cnt_d    = to_cnt_q + TO_W'(1);
    flags_d     = flags_q;
    key_reg_d   = key_reg_q;
    sample_d    = sample_q;
    frame_err_d = 1'b0;

    if ((state_q == ST_IDLE) || fall_c) begin
      to_cnt_d = '0;
    end

    // Timeout takes priority over an edge landing in the same cycle
    if (timeout_c) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
    end else if (fall_c) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {dat_sync_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(7)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = dat_sync_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!frame_ok_c) begin
            frame_err_d = 1'b1;
          end else if (shreg_q == SC_BREAK) begin
            flags_d.brk = 1'b1;
          end else if (shreg_q == SC_EXTENDED) begin
            flags_d.ext = 1'b1;
          end else if (flags_q.brk) begin
            if (is_shift_code(shreg_q)) begin
              flags_d.shift = 1'b0;
            end
            flags_d.brk = 1'b0;
            flags_d.ext = 1'b0;
          end else if (flags_q.ext) begin
            flags_d.ext = 1'b0;
          end else if (is_shift_code(shreg_q)) begin
            flags_d.shift = 1'b1;
          end else if (ascii_c != 8'h00) begin
            key_reg_d = ascii_c;
            sample_d  = ~sample_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign key_reg   = key_reg_q;
  assign sample    = sample_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_keyboard_source.sv
module tb_keyboard_source;

  localparam int unsigned TO = 400;

  logic       clock;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_reg;
  logic       sample;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  // Bench-side event counters; tests use differences only
  logic smp_q   = 1'b1;
  int   tog_cnt = 0;
  int   err_cnt = 0;

  keyboard_source #(.TIMEOUT_CYCLES(TO)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_reg   (key_reg),
    .sample    (sample),
    .frame_err (frame_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    smp_q <= sample;
    if (sample !== smp_q) tog_cnt <= tog_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present a bit, drop PS/2 clock; returns two cycles later, i.e. in the
  // cycle the DUT sees the falling edge (outputs update one cycle later).
  task automatic ps2_fall(input logic b);
    ps2_data = b;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(2);
  endtask

  task automatic ps2_rise();
    wait_cyc(8);
    ps2_clk = 1'b1;
    wait_cyc(3);
  endtask

  // Full frame up to the stop-bit edge; clock left low
  task automatic frame_head(input logic [7:0] code, input logic flip_par, input logic stop_b);
    ps2_fall(1'b0);
    ps2_rise();
    for (int i = 0; i < 8; i++) begin
      ps2_fall(code[i]);
      ps2_rise();
    end
    ps2_fall((~^code) ^ flip_par);
    ps2_rise();
    ps2_fall(stop_b);
  endtask

  task automatic send_byte(input logic [7:0] code);
    frame_head(code, 1'b0, 1'b1);
    ps2_rise();
  endtask

  task automatic test_reset();
    if (key_reg !== 8'h00) begin $display("FAIL reset_key got=%h want=00", key_reg); bad++; end
    total++;
    if (sample !== 1'b1) begin $display("FAIL reset_sample got=%b want=1", sample); bad++; end
    total++;
    if (frame_err !== 1'b0) begin $display("FAIL reset_err got=%b want=0", frame_err); bad++; end
    total++;
  endtask

  task automatic test_single_key();
    frame_head(8'h1C, 1'b0, 1'b1);
    if (key_reg !== 8'h00 || sample !== 1'b1) begin
      $display("FAIL early_update got=%h/%b want=00/1", key_reg, sample); bad++;
    end
    total++;
    wait_cyc(1);
    if (key_reg !== 8'h61 || sample !== 1'b0) begin
      $display("FAIL key_a got=%h/%b want=61/0", key_reg, sample); bad++;
    end
    total++;
    if (frame_err !== 1'b0) begin $display("FAIL a_err got=%b want=0", frame_err); bad++; end
    total++;
    ps2_rise();
  endtask

  task automatic test_shift_seq();
    int t0;
    t0 = tog_cnt;
    send_byte(8'h12);
    send_byte(8'h1C);
    if (key_reg !== 8'h41 || sample !== 1'b1) begin
      $display("FAIL shift_A got=%h/%b want=41/1", key_reg, sample); bad++;
    end
    total++;
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h12);
    send_byte(8'h1C);
    if (key_reg !== 8'h61 || sample !== 1'b0) begin
      $display("FAIL unshift_a got=%h/%b want=61/0", key_reg, sample); bad++;
    end
    total++;
    if (tog_cnt - t0 !== 2) begin $display("FAIL shift_toggles got=%0d want=2", tog_cnt - t0); bad++; end
    total++;
  endtask

  task automatic test_misc_map();
    int t0;
    send_byte(8'h29);
    if (key_reg !== 8'h20 || sample !== 1'b1) begin
      $display("FAIL space got=%h/%b want=20/1", key_reg, sample); bad++;
    end
    total++;
    send_byte(8'h66);
    if (key_reg !== 8'h08 || sample !== 1'b0) begin
      $display("FAIL bksp got=%h/%b want=08/0", key_reg, sample); bad++;
    end
    total++;
    send_byte(8'h45);
    if (key_reg !== 8'h30 || sample !== 1'b1) begin
      $display("FAIL digit0 got=%h/%b want=30/1", key_reg, sample); bad++;
    end
    total++;
    t0 = tog_cnt;
    send_byte(8'h76);
    if (key_reg !== 8'h30 || tog_cnt - t0 !== 0) begin
      $display("FAIL unmapped got=%h/%0d want=30/0", key_reg, tog_cnt - t0); bad++;
    end
    total++;
    send_byte(8'h45);
    if (key_reg !== 8'h30 || sample !== 1'b0) begin
      $display("FAIL repeat got=%h/%b want=30/0", key_reg, sample); bad++;
    end
    total++;
  endtask

  task automatic test_bad_frames();
    int t0;
    t0 = tog_cnt;
    frame_head(8'h29, 1'b1, 1'b1);
    if (frame_err !== 1'b0) begin $display("FAIL par_err_early got=%b want=0", frame_err); bad++; end
    total++;
    wait_cyc(1);
    if (frame_err !== 1'b1) begin $display("FAIL par_err got=%b want=1", frame_err); bad++; end
    total++;
    wait_cyc(1);
    if (frame_err !== 1'b0) begin $display("FAIL par_err_width got=%b want=0", frame_err); bad++; end
    total++;
    ps2_rise();
    if (key_reg !== 8'h30 || sample !== 1'b0 || tog_cnt - t0 !== 0) begin
      $display("FAIL par_hold got=%h/%b want=30/0", key_reg, sample); bad++;
    end
    total++;
    t0 = err_cnt;
    frame_head(8'h1C, 1'b0, 1'b0);
    ps2_rise();
    if (err_cnt - t0 !== 1 || key_reg !== 8'h30) begin
      $display("FAIL stop_err got=%0d/%h want=1/30", err_cnt - t0, key_reg); bad++;
    end
    total++;
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    ps2_fall(1'b0);
    ps2_rise();
    for (int i = 0; i < 4; i++) begin
      ps2_fall(1'b1);
      ps2_rise();
    end
    wait_cyc(TO - 40);
    if (err_cnt - e0 !== 0) begin $display("FAIL to_early got=%0d want=0", err_cnt - e0); bad++; end
    total++;
    wait_cyc(60);
    if (err_cnt - e0 !== 1) begin $display("FAIL timeout got=%0d want=1", err_cnt - e0); bad++; end
    total++;
    send_byte(8'h5A);
    if (key_reg !== 8'h0D || sample !== 1'b1) begin
      $display("FAIL after_to got=%h/%b want=0d/1", key_reg, sample); bad++;
    end
    total++;
  endtask

  task automatic test_extended();
    int t0;
    t0 = tog_cnt;
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'h05);
    if (key_reg !== 8'h0D || tog_cnt - t0 !== 0) begin
      $display("FAIL ext_ignore got=%h/%0d want=0d/0", key_reg, tog_cnt - t0); bad++;
    end
    total++;
    send_byte(8'h1C);
    if (key_reg !== 8'h61 || sample !== 1'b0) begin
      $display("FAIL ext_cleared got=%h/%b want=61/0", key_reg, sample); bad++;
    end
    total++;
  endtask

  task automatic test_reset_mid();
    int e0;
    ps2_fall(1'b0);
    ps2_rise();
    for (int i = 0; i < 3; i++) begin
      ps2_fall(1'b1);
      ps2_rise();
    end
    resetn = 1'b0;
    #2;
    if (key_reg !== 8'h00 || sample !== 1'b1 || frame_err !== 1'b0) begin
      $display("FAIL mid_reset got=%h/%b/%b want=00/1/0", key_reg, sample, frame_err); bad++;
    end
    total++;
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(3);
    e0 = err_cnt;
    send_byte(8'h16);
    if (key_reg !== 8'h31 || sample !== 1'b0 || err_cnt - e0 !== 0) begin
      $display("FAIL post_reset got=%h/%b/%0d want=31/0/0", key_reg, sample, err_cnt - e0); bad++;
    end
    total++;
  endtask

  initial begin
    resetn   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    test_reset();
    resetn = 1'b1;
    wait_cyc(3);
    test_single_key();
    test_shift_seq();
    test_misc_map();
    test_bad_frames();
    test_timeout();
    test_extended();
    test_reset_mid();
    wait_cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
